mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and single-port memory signals shared by the arbiter and its neighbours.
// slave: arbiter view; master: requester/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_flush;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports; grant is combinational, read data returns 1 cycle later.
// No queueing: a losing requester holds its request until granted; fetch is forced through after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk1,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          both_req;
    logic          fetch_forced;
    logic          gnt_if;
    logic          gnt_d;
    logic          rvalid_if;
    logic          rvalid_d;
    logic [DW-1:0] if_hold;
    logic [DW-1:0] d_hold;

    always_comb begin
        both_req     = bus.if_req && bus.d_req;
        fetch_forced = both_req && (starve_cnt == SW'(STARVE_MAX));
        gnt_d        = !rst && bus.d_req && !fetch_forced;
        gnt_if       = !rst && bus.if_req && !gnt_d;
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.mem_en    = gnt_if || gnt_d;
    assign bus.mem_we    = gnt_d && bus.d_we;
    assign bus.mem_addr  = gnt_d ? bus.d_addr : (gnt_if ? bus.if_addr : {AW{1'b0}});
    assign bus.mem_wdata = gnt_d ? bus.d_wdata : {DW{1'b0}};

    always_ff @(posedge clk1) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (gnt_if) begin
            starve_cnt <= '0;
        end else if (both_req && gnt_d && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush in the grant cycle still grants the fetch but drops its response.
    always_comb begin
        state_nxt = IDLE;
        rvalid_if = 1'b0;
        rvalid_d  = 1'b0;
        if (gnt_if && !bus.if_flush) begin
            state_nxt = RD_IF;
        end else if (gnt_d && !bus.d_we) begin
            state_nxt = RD_D;
        end
        if (!rst) begin
            rvalid_if = (state == RD_IF) && !bus.if_flush;
            rvalid_d  = (state == RD_D);
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            if_hold <= '0;
            d_hold  <= '0;
        end else begin
            if (rvalid_if) if_hold <= bus.mem_rdata;
            if (rvalid_d)  d_hold  <= bus.mem_rdata;
        end
    end

    assign bus.if_rvalid = rvalid_if;
    assign bus.d_rvalid  = rvalid_d;
    assign bus.if_rdata  = rst ? {DW{1'b0}} : (rvalid_if ? bus.mem_rdata : if_hold);
    assign bus.d_rdata   = rst ? {DW{1'b0}} : (rvalid_d ? bus.mem_rdata : d_hold);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 3;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];

    // Synchronous single-port memory environment.
    always @(posedge clk1) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: losses counter, one pending response, shadow memory fed by expected stores.
    int            m_losses = 0;
    int            m_pend   = 0;   // 0 none, 1 fetch, 2 load
    logic [AW-1:0] m_paddr  = '0;
    logic [DW-1:0] m_last_if = '0;
    logic [DW-1:0] m_last_d  = '0;

    always @(negedge clk1) begin
        logic e_ig, e_dg, e_ir, e_dr;
        if (rst) begin
            e_ig = 1'b0;
            e_dg = 1'b0;
        end else if (bus.if_req && bus.d_req) begin
            e_ig = (m_losses == SMAX);
            e_dg = !e_ig;
        end else begin
            e_ig = bus.if_req;
            e_dg = bus.d_req;
        end
        e_ir = !rst && (m_pend == 1) && !bus.if_flush;
        e_dr = !rst && (m_pend == 2);
        if (rst) begin
            m_last_if = '0;
            m_last_d  = '0;
        end else begin
            if (e_ir) m_last_if = ref_mem[m_paddr];
            if (e_dr) m_last_d  = ref_mem[m_paddr];
        end

        chk("m_if_gnt",    bus.if_gnt,    e_ig);
        chk("m_d_gnt",     bus.d_gnt,     e_dg);
        chk("m_mem_en",    bus.mem_en,    e_ig || e_dg);
        chk("m_mem_we",    bus.mem_we,    e_dg && bus.d_we);
        if (e_dg) chk("m_mem_addr_d", bus.mem_addr, bus.d_addr);
        if (e_ig) chk("m_mem_addr_if", bus.mem_addr, bus.if_addr);
        if (e_dg && bus.d_we) chk("m_mem_wdata", bus.mem_wdata, bus.d_wdata);
        chk("m_if_rvalid", bus.if_rvalid, e_ir);
        chk("m_d_rvalid",  bus.d_rvalid,  e_dr);
        chk("m_if_rdata",  bus.if_rdata,  m_last_if);
        chk("m_d_rdata",   bus.d_rdata,   m_last_d);

        if (rst)                                 m_losses = 0;
        else if (e_ig)                           m_losses = 0;
        else if (bus.if_req && bus.d_req && e_dg) m_losses = (m_losses < SMAX) ? m_losses + 1 : SMAX;

        if (rst) m_pend = 0;
        else if (e_ig && !bus.if_flush) begin m_pend = 1; m_paddr = bus.if_addr; end
        else if (e_dg && !bus.d_we)     begin m_pend = 2; m_paddr = bus.d_addr;  end
        else m_pend = 0;

        if (!rst && e_dg && bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic look();
        @(negedge clk1);
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    initial begin
        string pat;
        int    sc [8];
        byte   g;
        pat = "DDDIDDDI";
        sc  = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = (i < 4) ? 32'h2801000a + i : 32'h10000000 + i * 3;
            ref_mem[i] = mem[i];
        end
        idle_inputs();
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;

        // Reset gates grants even with both requesting.
        look();
        step();
        look();
        chk("rst_if_gnt", bus.if_gnt, 0);
        chk("rst_d_gnt", bus.d_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);

        // Fetch stream, granted from the first non-reset cycle.
        for (int i = 0; i < 4; i++) begin
            step();
            rst = 1'b0;
            bus.d_req = 1'b0;
            bus.if_req = 1'b1;
            bus.if_addr = AW'(i);
            look();
            chk("fetch_gnt", bus.if_gnt, 1);
            if (i > 0) begin
                chk("fetch_rvalid", bus.if_rvalid, 1);
                chk("fetch_rdata", bus.if_rdata, 32'h2801000a + i - 1);
            end
        end
        step();
        bus.if_req = 1'b0;
        look();
        chk("fetch_last_rvalid", bus.if_rvalid, 1);
        chk("fetch_last_rdata", bus.if_rdata, 32'h2801000d);

        // Contention: data wins three times, then fetch is forced through.
        for (int k = 0; k < 8; k++) begin
            step();
            bus.if_req = 1'b1; bus.if_addr = 10'd60;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd50;
            look();
            g = bus.d_gnt ? "D" : (bus.if_gnt ? "I" : "-");
            chk("contention_pattern", g, pat[k]);
            chk("contention_starve", int'(dut.starve_cnt), sc[k]);
        end

        // Store then load to the same word.
        step();
        idle_inputs();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd121; bus.d_wdata = 32'd130;
        look();
        chk("store_gnt", bus.d_gnt, 1);
        chk("store_mem_we", bus.mem_we, 1);
        step();
        bus.d_we = 1'b0;
        look();
        chk("load_gnt", bus.d_gnt, 1);
        chk("store_no_rvalid", bus.d_rvalid, 0);
        step();
        bus.d_req = 1'b0;
        look();
        chk("load_rvalid", bus.d_rvalid, 1);
        chk("load_rdata", bus.d_rdata, 130);

        // Flush in grant cycle, flush in response cycle, then a clean fetch.
        step();
        bus.if_req = 1'b1; bus.if_addr = 10'd8; bus.if_flush = 1'b1;
        look();
        chk("flush_grant_cycle_gnt", bus.if_gnt, 1);
        step();
        bus.if_addr = 10'd5; bus.if_flush = 1'b0;
        look();
        chk("flush_addr5_gnt", bus.if_gnt, 1);
        chk("flush_addr8_suppressed", bus.if_rvalid, 0);
        step();
        bus.if_req = 1'b0; bus.if_flush = 1'b1;
        look();
        chk("flush_addr5_suppressed", bus.if_rvalid, 0);
        step();
        bus.if_flush = 1'b0; bus.if_req = 1'b1; bus.if_addr = 10'd9;
        look();
        chk("flush_addr9_gnt", bus.if_gnt, 1);
        step();
        bus.if_req = 1'b0;
        look();
        chk("flush_addr9_rvalid", bus.if_rvalid, 1);
        chk("flush_addr9_rdata", bus.if_rdata, 32'h1000001b);

        // Reset while a load is in flight.
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd121;
        look();
        chk("rstread_gnt", bus.d_gnt, 1);
        step();
        bus.d_req = 1'b0; rst = 1'b1;
        look();
        chk("rstread_rvalid", bus.d_rvalid, 0);
        chk("rstread_d_rdata", bus.d_rdata, 0);
        chk("rstread_if_rdata", bus.if_rdata, 0);
        chk("rstread_mem_en", bus.mem_en, 0);
        step();
        rst = 1'b0;
        look();
        chk("rstread_after_rvalid", bus.d_rvalid, 0);
        chk("rstread_starve", int'(dut.starve_cnt), 0);

        // Idle.
        for (int k = 0; k < 5; k++) begin
            step();
            idle_inputs();
            look();
            chk("idle_mem_en", bus.mem_en, 0);
            chk("idle_if_rvalid", bus.if_rvalid, 0);
            chk("idle_d_rvalid", bus.d_rvalid, 0);
        end

        // Mixed traffic, checked by the model only.
        for (int k = 0; k < 60; k++) begin
            step();
            bus.if_req   = 1'($urandom_range(0, 1));
            bus.if_addr  = AW'($urandom_range(0, 15));
            bus.if_flush = ($urandom_range(0, 3) == 0);
            bus.d_req    = 1'($urandom_range(0, 1));
            bus.d_we     = 1'($urandom_range(0, 1));
            bus.d_addr   = AW'($urandom_range(0, 15));
            bus.d_wdata  = $urandom;
        end
        step();
        idle_inputs();
        repeat (2) step();
        look();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
